pipelined_adder: RTL



---
 rtl/pipelined_adder.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: STAGES ripple slices with registered inter-slice carries and a valid/ready handshake.
// Define OVF_FLAG_EN to add the registered signed-overflow output o_ovf.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_out_valid,
`ifdef OVF_FLAG_EN
  output logic             o_ovf,
`endif
  input  logic             i_out_ready
);

  localparam int SW = WIDTH / STAGES;

  logic w_adv;

  // The whole pipe advances together; it only stalls when a result is waiting and not taken.
  assign w_adv      = !o_out_valid || i_out_ready;
  assign o_in_ready = w_adv;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Operand bits still to be added: this stage's slice plus all slices above it.
      logic [WIDTH-gi*SW-1:0] w_a_in;
      logic [WIDTH-gi*SW-1:0] w_b_in;
      logic                   w_vld_in;
      logic                   w_cin;
      logic [SW:0]            w_add;
      logic [(gi+1)*SW-1:0]   w_sum_next;

      logic                   r_vld;
      logic                   r_carry;
      logic [(gi+1)*SW-1:0]   r_sum;

      if (gi == 0) begin : g_src
        assign w_a_in     = i_a;
        assign w_b_in     = i_b;
        assign w_vld_in   = i_in_valid;
        assign w_cin      = i_cin;
        assign w_sum_next = w_add[SW-1:0];
      end else begin : g_src
        assign w_a_in     = g_stage[gi-1].g_hi.r_a;
        assign w_b_in     = g_stage[gi-1].g_hi.r_b;
        assign w_vld_in   = g_stage[gi-1].r_vld;
        assign w_cin      = g_stage[gi-1].r_carry;
        assign w_sum_next = {w_add[SW-1:0], g_stage[gi-1].r_sum};
      end

      assign w_add = {1'b0, w_a_in[SW-1:0]} + {1'b0, w_b_in[SW-1:0]} + {{SW{1'b0}}, w_cin};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld   <= 1'b0;
          r_carry <= 1'b0;
          r_sum   <= '0;
        end else if (w_adv) begin
          r_vld   <= w_vld_in;
          r_carry <= w_add[SW];
          r_sum   <= w_sum_next;
        end
      end

      // Skew registers: unprocessed upper operand slices, not needed after the last stage.
      if (gi < STAGES - 1) begin : g_hi
        logic [WIDTH-(gi+1)*SW-1:0] r_a;
        logic [WIDTH-(gi+1)*SW-1:0] r_b;

        always_ff @(posedge clk) begin
          if (w_adv) begin
            r_a <= w_a_in[WIDTH-gi*SW-1:SW];
            r_b <= w_b_in[WIDTH-gi*SW-1:SW];
          end
        end
      end

`ifdef OVF_FLAG_EN
      if (gi == STAGES - 1) begin : g_ovf
        logic w_ovf_next;
        logic r_ovf;

        // The top slice sees the operand MSBs, so overflow is resolved here alongside the sum MSB.
        assign w_ovf_next = (w_a_in[SW-1] == w_b_in[SW-1]) && (w_add[SW-1] != w_a_in[SW-1]);

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_ovf <= 1'b0;
          end else if (w_adv) begin
            r_ovf <= w_ovf_next;
          end
        end

        assign o_ovf = r_ovf;
      end
`endif
    end
  endgenerate

  assign o_sum       = g_stage[STAGES-1].r_sum;
  assign o_cout      = g_stage[STAGES-1].r_carry;
  assign o_out_valid = g_stage[STAGES-1].r_vld;

endmodule
